// File: rtl/deserializer.sv
// deserializer
//
// Receive-side counterpart of the chunk serializer. Collects a burst of
// OUTWIDTH-bit chunks, lowest chunk first, into one INWIDTH-bit word and
// offers that word to a consumer. At the input of the hash datapath it
// rebuilds 256-bit blocks from an 8-bit byte stream.
//
// Parameters
//   INWIDTH   width of the assembled word (integer multiple of OUTWIDTH)
//   OUTWIDTH  width of one incoming chunk
//   NCHUNK    INWIDTH/OUTWIDTH, chunks per full word (derived, not a port)
//
// Ports
//   clk           single clock, everything on posedge
//   reset         synchronous reset, active low (asserted when 0)
//   start         one-cycle pulse that begins a capture of `length` chunks
//   length        chunk count of the capture, sampled only with start;
//                 0 means "no capture", values above NCHUNK clamp to NCHUNK
//   serial_in     incoming chunk
//   serial_valid  serial_in carries a chunk this cycle
//   out           assembled word
//   out_valid     out holds a complete word
//   out_ready     consumer accepts out this cycle
//   busy          a capture or a hold is in progress
//   overflow      (only with DESERIALIZER_OVERFLOW_EN) sticky dropped-chunk flag
//
// Build option
//   DESERIALIZER_OVERFLOW_EN  adds the `overflow` output. Without it, chunks
//                             that arrive outside a capture are dropped
//                             silently; all other behaviour is identical.
//
// Output handshake: a word is transferred on every posedge where out_valid
// and out_ready are both 1. While out_valid is 1 and out_ready is 0, out and
// out_valid hold steady. out_valid never drops without a transfer except on
// reset. out_ready has no effect while out_valid is 0.
//
// State is kept in the enum `state` (IDLE / COLLECT / HOLD); busy is its
// registered "not IDLE" image.

module deserializer #(
  parameter int INWIDTH  = 256,
  parameter int OUTWIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(INWIDTH/OUTWIDTH):0]      length,
  input  logic [OUTWIDTH-1:0]                    serial_in,
  input  logic                                   serial_valid,
  output logic [INWIDTH-1:0]                     out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
`ifdef DESERIALIZER_OVERFLOW_EN
  ,
  output logic                                   overflow
`endif
);

  localparam int NCHUNK = INWIDTH / OUTWIDTH;
  localparam int IDXW   = $clog2(NCHUNK);
  localparam int LENW   = IDXW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] index;   // slot the next chunk is written into
  logic [LENW-1:0] count;   // chunks in the current capture, 1..NCHUNK

  // Requested length limited to a full word. Because count never exceeds
  // NCHUNK, index stops at NCHUNK-1 and cannot wrap.
  logic [LENW-1:0] len_clamped;
  logic            len_nonzero;
  logic            last_chunk;

  always_comb begin
    len_clamped = (length > LENW'(NCHUNK)) ? LENW'(NCHUNK) : length;
    len_nonzero = (length != '0);
    // count is at least 1 whenever COLLECT is entered, so count-1 is safe.
    last_chunk  = ({1'b0, index} == (count - LENW'(1)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      index     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A chunk arriving together with start is not captured: the
          // serializer delivers its first chunk one cycle after its load.
          if (start && len_nonzero) begin
            count <= len_clamped;
            out   <= '0;
            index <= '0;
            busy  <= 1'b1;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (start) begin
            // Abort and restart; any chunk on this cycle belongs to the
            // abandoned capture and is discarded.
            out   <= '0;
            index <= '0;
            if (len_nonzero) begin
              count <= len_clamped;
            end else begin
              // A zero-length restart has nothing to collect: the old
              // capture is dropped and the block goes idle.
              count <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (serial_valid) begin
            out[index*OUTWIDTH +: OUTWIDTH] <= serial_in;
            if (last_chunk) begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              index <= index + IDXW'(1);
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start && len_nonzero) begin
              // Back-to-back: the transfer and the next capture's start
              // share this edge.
              count <= len_clamped;
              out   <= '0;
              index <= '0;
              state <= COLLECT;
            end else begin
              // out keeps the transferred word until the next start.
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          index     <= '0;
          count     <= '0;
        end
      endcase
    end
  end

`ifdef DESERIALIZER_OVERFLOW_EN
  // A chunk is lost when it arrives outside COLLECT, or on a restart edge.
  logic chunk_dropped;
  logic idle_accept;

  always_comb begin
    chunk_dropped = serial_valid && ((state != COLLECT) || start);
    idle_accept   = (state == IDLE) && start && len_nonzero;
  end

  // Sticky. A start accepted from IDLE clears it, but a chunk dropped on
  // that same edge is still reported: setting wins over clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (chunk_dropped) begin
      overflow <= 1'b1;
    end else if (idle_accept) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer (default parameters, 256-bit word of bytes).
// A behavioural model keeps the received chunks of the current capture in a
// queue and forms the expected word arithmetically; a compare process checks
// out / out_valid / busy against it on every falling edge. Directed steps add
// hand-computed literal checks at key points.

module tb_deserializer;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   length;
  logic [7:0]   serial_in;
  logic         serial_valid;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef DESERIALIZER_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
`ifdef DESERIALIZER_OVERFLOW_EN
    ,
    .overflow     (overflow)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_capturing;
  bit         m_holding;
  int         m_target;
  logic [7:0] m_chunks[$];
  logic [W-1:0] m_out;
  bit         m_valid;
  bit         m_ovf;

  function automatic logic [W-1:0] packed_word();
    logic [W-1:0] w = '0;
    foreach (m_chunks[i]) w = w | (W'(m_chunks[i]) << (8 * i));
    return w;
  endfunction

  task automatic m_begin();
    m_capturing = 1'b1;
    m_target    = (int'(length) > 32) ? 32 : int'(length);
    m_chunks.delete();
    m_out       = '0;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_capturing = 1'b0;
      m_holding   = 1'b0;
      m_chunks.delete();
      m_out       = '0;
      m_valid     = 1'b0;
      m_ovf       = 1'b0;
    end else begin
      // Overflow: start from idle clears, a dropped chunk sets (set wins).
      if (!m_capturing && !m_holding && start && length != 0) m_ovf = 1'b0;
      if (serial_valid && (!m_capturing || start)) m_ovf = 1'b1;

      if (m_holding) begin
        if (out_ready) begin
          m_holding = 1'b0;
          m_valid   = 1'b0;
          if (start && length != 0) m_begin();
        end
      end else if (m_capturing) begin
        if (start) begin
          if (length != 0) m_begin();
          else begin
            m_capturing = 1'b0;
            m_chunks.delete();
            m_out = '0;
          end
        end else if (serial_valid) begin
          m_chunks.push_back(serial_in);
          m_out = packed_word();
          if (m_chunks.size() == m_target) begin
            m_capturing = 1'b0;
            m_holding   = 1'b1;
            m_valid     = 1'b1;
          end
        end
      end else if (start && length != 0) begin
        m_begin();
      end
    end
  end

  // Outputs are registered, so the falling edge sees the settled values.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_out", out, m_out);
      chk("cyc_out_valid", W'(out_valid), W'(m_valid));
      chk("cyc_busy", W'(busy), W'(m_capturing || m_holding));
`ifdef DESERIALIZER_OVERFLOW_EN
      chk("cyc_overflow", W'(overflow), W'(m_ovf));
`endif
    end
  end

  // ---------------- driver ----------------
  // One step = one clock: inputs change on the falling edge and are
  // consumed by the following rising edge.
  task automatic step(input bit st, input logic [5:0] len, input bit sv,
                      input logic [7:0] si, input bit rdy);
    @(negedge clk);
    start        = st;
    length       = len;
    serial_valid = sv;
    serial_in    = si;
    out_ready    = rdy;
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chunk(input logic [7:0] d);
    step(1'b0, 6'd0, 1'b1, d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0; length = '0; serial_valid = 1'b0; serial_in = '0; out_ready = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    reset = 1'b1;

    // Full word of 32 bytes 0x00..0x1F.
    step(1'b1, 6'd32, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chunk(8'(i));
      if (i == 31) chk("full_not_early", W'(out_valid), W'(0));
    end
    idle();
    chk("full_valid", W'(out_valid), W'(1));
    chk("full_word", out, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    step(1'b0, 6'd0, 1'b0, 8'h00, 1'b1);
    idle();
    chk("full_drop_valid", W'(out_valid), W'(0));
    chk("full_keep_out", out, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);

    // Short burst with gaps.
    step(1'b1, 6'd3, 1'b0, 8'h00, 1'b0);
    chunk(8'hAA); idle(); chunk(8'hBB); idle(); idle(); chunk(8'hCC);
    chk("gap_not_early", W'(out_valid), W'(0));
    idle();
    chk("gap_word", out, 256'hccbbaa);
    chk("gap_valid", W'(out_valid), W'(1));
    step(1'b0, 6'd0, 1'b0, 8'h00, 1'b1);
    idle();

    // Backpressure: 10 held cycles with 0xFF chunks that must be dropped.
    step(1'b1, 6'd4, 1'b0, 8'h00, 1'b0);
    chunk(8'h01); chunk(8'h02); chunk(8'h03); chunk(8'h04);
    for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 1'b1, 8'hFF, 1'b0);
    chk("bp_word", out, 256'h04030201);
    chk("bp_valid", W'(out_valid), W'(1));
    step(1'b0, 6'd0, 1'b1, 8'hFF, 1'b1);
    idle();
    chk("bp_released", W'(out_valid), W'(0));
    chk("bp_idle", W'(busy), W'(0));
    chk("bp_keep", out, 256'h04030201);

    // Restart after 5 chunks, then back-to-back start with the handshake.
    step(1'b1, 6'd32, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) chunk(8'h50 + 8'(i));
    step(1'b1, 6'd2, 1'b1, 8'h99, 1'b0);
    chunk(8'h11); chunk(8'h22);
    step(1'b1, 6'd1, 1'b0, 8'h00, 1'b1);
    chk("restart_word", out, 256'h2211);
    chk("restart_valid", W'(out_valid), W'(1));
    chunk(8'h33);
    chk("b2b_gap", W'(out_valid), W'(0));
    chk("b2b_cleared", out, '0);
    idle();
    chk("b2b_word", out, 256'h33);
    chk("b2b_valid", W'(out_valid), W'(1));
    step(1'b0, 6'd0, 1'b0, 8'h00, 1'b1);
    idle();

    // Boundary lengths: 0 is ignored, 40 clamps to 32.
    step(1'b1, 6'd0, 1'b0, 8'h00, 1'b0);
    idle();
    chk("len0_idle", W'(busy), W'(0));
    step(1'b1, 6'd40, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) chunk(8'hA0 + 8'(i));
    idle();
    chk("len40_valid", W'(out_valid), W'(1));
    chk("len40_top", out[255:248], W'(8'hBF));
    step(1'b0, 6'd0, 1'b0, 8'h00, 1'b1);
    idle();

    // Reset during COLLECT at index 10.
    step(1'b1, 6'd32, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) chunk(8'h70 + 8'(i));
    step(1'b0, 6'd0, 1'b1, 8'h7A, 1'b0);
    reset = 1'b0;
    chunk(8'h7B);
    reset = 1'b1;
    chk("rst_col_out", out, '0);
    chk("rst_col_busy", W'(busy), W'(0));
    chunk(8'h7C); chunk(8'h7D);
    idle();
    chk("rst_col_ignored", out, '0);

    // Reset during HOLD.
    step(1'b1, 6'd1, 1'b0, 8'h00, 1'b0);
    chunk(8'h5A);
    idle();
    chk("hold_valid", W'(out_valid), W'(1));
    reset = 1'b0;
    idle();
    reset = 1'b1;
    chk("rst_hold_out", out, '0);
    chk("rst_hold_valid", W'(out_valid), W'(0));
    chk("rst_hold_busy", W'(busy), W'(0));
    chunk(8'h66);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
